// File: rtl/pc_gen_pkg.sv
// Shared defaults and the next-PC source encoding for the fetch-PC generator.
package pc_gen_pkg;

  localparam int unsigned DEF_XLEN       = 32;
  localparam int unsigned DEF_INST_BYTES = 4;
  localparam int unsigned DEF_RAS_DEPTH  = 4;
  localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC   = 32'h0000_0100;

  // Next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    NPC_TRAP  = 3'd0,
    NPC_REDIR = 3'd1,
    NPC_HOLD  = 3'd2,
    NPC_RAS   = 3'd3,
    NPC_PRED  = 3'd4,
    NPC_SEQ   = 3'd5
  } npc_sel_e;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; count saturates at DEPTH. Clear resets only pointer/count.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_replace,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty,
  output logic            o_full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_entry [DEPTH];
  logic [PW-1:0]   w_top_idx;

  // The newest entry sits just below the write pointer; wraps with DEPTH a power of 2.
  assign w_top_idx = r_ptr - PW'(1);
  assign o_top     = r_entry[w_top_idx];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));

  // Pointer and occupancy count; reset or clear forgets every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!o_full) r_count <= r_count + CW'(1);
    end else if (i_pop) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CW'(1);
    end
  end

  // Entry storage: push writes at the pointer, replace rewrites the top in place.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_entry[r_ptr] <= i_data;
    end else if (i_replace) begin
      r_entry[w_top_idx] <= i_data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: PC register, pc_valid flop, priority next-PC mux and
// a return-address stack for call/return prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
  parameter int unsigned     INST_BYTES = DEF_INST_BYTES,
  parameter int unsigned     RAS_DEPTH  = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            trap,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  input  logic            pred_call,
  input  logic            pred_ret,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES) - XLEN'(1));

  logic [XLEN-1:0] r_pc;
  logic            r_pc_valid;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_npc;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_ras_en;
  logic            w_ret_hit;
  logic            w_push;
  logic            w_pop;
  logic            w_replace;
  npc_sel_e        w_sel;

  assign w_seq_pc  = r_pc + XLEN'(INST_BYTES);
  assign w_ret_hit = pred_ret & ~w_ras_empty;
  // Trap, redirect and stall all freeze the stack; so does the first
  // post-reset cycle, when the PC is not yet a real fetch address.
  assign w_ras_en  = r_pc_valid & ~trap & ~redirect & ~stall;
  // Call+return with a non-empty stack swaps the top; with an empty stack it is a plain push.
  assign w_push    = w_ras_en & pred_call & ~w_ret_hit;
  assign w_replace = w_ras_en & pred_call &  w_ret_hit;
  assign w_pop     = w_ras_en & ~pred_call & w_ret_hit;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (trap),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_replace (w_replace),
    .i_data    (w_seq_pc),
    .o_top     (w_ras_top),
    .o_empty   (w_ras_empty),
    .o_full    (w_ras_full)
  );

  // Next-PC source selection in priority order; the PC holds on the first edge after reset.
  always_comb begin
    w_sel = NPC_SEQ;
    if (!r_pc_valid)     w_sel = NPC_HOLD;
    else if (trap)       w_sel = NPC_TRAP;
    else if (redirect)   w_sel = NPC_REDIR;
    else if (stall)      w_sel = NPC_HOLD;
    else if (w_ret_hit)  w_sel = NPC_RAS;
    else if (pred_taken) w_sel = NPC_PRED;
  end

  // Next-PC data mux; redirect and predicted targets are forced to instruction alignment.
  always_comb begin
    w_npc = w_seq_pc;
    unique case (w_sel)
      NPC_TRAP:  w_npc = TRAP_VEC;
      NPC_REDIR: w_npc = redirect_pc & ALIGN_MASK;
      NPC_HOLD:  w_npc = r_pc;
      NPC_RAS:   w_npc = w_ras_top;
      NPC_PRED:  w_npc = pred_target & ALIGN_MASK;
      default:   w_npc = w_seq_pc;
    endcase
  end

  // PC register and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VEC;
      r_pc_valid <= 1'b0;
    end else begin
      r_pc       <= w_npc;
      r_pc_valid <= 1'b1;
    end
  end

  assign pc        = r_pc;
  assign pc_valid  = r_pc_valid;
  assign ras_empty = w_ras_empty;
  assign ras_full  = w_ras_full;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: each step drives the inputs, queues the PC
// expected after the next edge, then pops and compares after that edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, trap = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = '0;
  logic        pred_call = 1'b0, pred_ret = 1'b0;
  logic [31:0] pc;
  logic        pc_valid, ras_empty, ras_full;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .trap(trap),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_call(pred_call), .pred_ret(pred_ret),
    .pc(pc), .pc_valid(pc_valid), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  // Time bound for the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic st, input logic tr, input logic rd, input logic [31:0] rpc,
                     input logic tk, input logic [31:0] tg, input logic cl, input logic rt);
    stall = st; trap = tr; redirect = rd; redirect_pc = rpc;
    pred_taken = tk; pred_target = tg; pred_call = cl; pred_ret = rt;
  endtask

  task automatic idle();
    drv(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  // One clock step: queue the expected PC, take the edge, pop and compare.
  task automatic tick(input string tag, input logic [31:0] exp_pc);
    logic [31:0] e;
    exp_q.push_back(exp_pc);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk(tag, pc, e);
    $display("step %-12s pc=%h valid=%0b empty=%0b full=%0b", tag, pc, pc_valid, ras_empty, ras_full);
  endtask

  initial begin
    // Reset held for three cycles.
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'd0);
    chk("rst_empty", {31'b0, ras_empty}, 32'd1);
    chk("rst_full", {31'b0, ras_full}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_valid0", {31'b0, pc_valid}, 32'd0);
    tick("rel_hold", 32'h0);
    chk("rel_valid1", {31'b0, pc_valid}, 32'd1);
    tick("seq4", 32'h4);
    tick("seq8", 32'h8);
    tick("seqC", 32'hC);

    // Trap beats redirect beats stall.
    drv(1, 1, 1, 32'h200, 0, 0, 0, 0);
    tick("prio_trap", 32'h100);
    chk("prio_empty", {31'b0, ras_empty}, 32'd1);

    // Stall holds; redirect overrides stall and is aligned.
    drv(0, 0, 1, 32'h40, 0, 0, 0, 0);
    tick("redir_40", 32'h40);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick("stall_hold", 32'h40);
    drv(1, 0, 1, 32'h83, 0, 0, 0, 0);
    tick("stall_redir", 32'h80);

    // Nested call/return.
    drv(0, 0, 1, 32'h10, 0, 0, 0, 0);
    tick("redir_10", 32'h10);
    drv(0, 0, 0, 0, 1, 32'h100, 1, 0);
    tick("call1", 32'h100);
    chk("call1_empty", {31'b0, ras_empty}, 32'd0);
    idle();
    tick("seq104", 32'h104);
    drv(0, 0, 0, 0, 1, 32'h200, 1, 0);
    tick("call2", 32'h200);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    tick("ret1", 32'h108);
    tick("ret2", 32'h14);
    chk("ret_empty", {31'b0, ras_empty}, 32'd1);

    // Overflow: five calls into four entries, then five returns.
    drv(0, 0, 0, 0, 1, 32'h1000, 1, 0); tick("ovf_call1", 32'h1000);
    drv(0, 0, 0, 0, 1, 32'h2000, 1, 0); tick("ovf_call2", 32'h2000);
    drv(0, 0, 0, 0, 1, 32'h3000, 1, 0); tick("ovf_call3", 32'h3000);
    drv(0, 0, 0, 0, 1, 32'h4000, 1, 0); tick("ovf_call4", 32'h4000);
    chk("ovf_full4", {31'b0, ras_full}, 32'd1);
    drv(0, 0, 0, 0, 1, 32'h5000, 1, 0); tick("ovf_call5", 32'h5000);
    chk("ovf_full5", {31'b0, ras_full}, 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    tick("ovf_ret1", 32'h4004);
    chk("ovf_notfull", {31'b0, ras_full}, 32'd0);
    tick("ovf_ret2", 32'h3004);
    tick("ovf_ret3", 32'h2004);
    tick("ovf_ret4", 32'h1004);
    chk("ovf_empty", {31'b0, ras_empty}, 32'd1);
    tick("ovf_ret5", 32'h1008);

    // Call+return: empty stack acts as a push; non-empty swaps the top.
    drv(0, 0, 0, 0, 0, 0, 1, 1);
    tick("cr_empty", 32'h100C);
    chk("cr_pushed", {31'b0, ras_empty}, 32'd0);
    drv(0, 0, 0, 0, 1, 32'h7000, 1, 1);
    tick("cr_swap", 32'h100C);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    tick("cr_ret", 32'h1010);
    chk("cr_empty2", {31'b0, ras_empty}, 32'd1);

    // Trap clears a non-empty stack.
    drv(0, 0, 0, 0, 1, 32'h3000, 1, 0);
    tick("trap_call", 32'h3000);
    drv(0, 1, 0, 0, 0, 0, 0, 1);
    tick("trap_go", 32'h100);
    chk("trap_clr", {31'b0, ras_empty}, 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    tick("trap_ret_seq", 32'h104);

    // Predicted target alignment, then redirect gating a call.
    drv(0, 0, 0, 0, 1, 32'h1237, 0, 0);
    tick("pred_align", 32'h1234);
    drv(0, 0, 1, 32'h500, 0, 0, 1, 0);
    tick("redir_gate", 32'h500);
    chk("redir_nopush", {31'b0, ras_empty}, 32'd1);

    // Wrap from the top of the address space.
    drv(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    tick("to_top", 32'hFFFF_FFFC);
    idle();
    tick("wrap", 32'h0);

    // Asynchronous reset mid-operation discards the stack at once.
    drv(0, 0, 0, 0, 1, 32'h600, 1, 0);
    tick("mid_call", 32'h600);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", {31'b0, pc_valid}, 32'd0);
    chk("arst_empty", {31'b0, ras_empty}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick("arst_hold", 32'h0);
    tick("arst_seq", 32'h4);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    tick("arst_ret_seq", 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
